// File: rtl/updn_pkg.sv
// rtl/updn_pkg.sv - shared types and default widths for the up/down counter command sequencer
//
// Contents:
//   op_t      command opcodes (HOLD=0, LOAD=1, UP=2, DOWN=3), matching the cmd_op port encoding
//   state_t   sequencer FSM states (IDLE, RUN)
//   WIDTH_DEF / LEN_W_DEF  default counter data width and run-length width
package updn_pkg;

    localparam int WIDTH_DEF = 3;
    localparam int LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/updn_len_cnt.sv
// rtl/updn_len_cnt.sv - loadable run-length down-counter with last/zero flags
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset (count -> 0)
//   load      in   load load_val (has priority over dec)
//   load_val  in   LEN_W value to load
//   dec       in   decrement by one; saturates at zero
//   last      out  count == 1
//   zero      out  count == 0
module updn_len_cnt
    import updn_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             last,
    output logic             zero
);

    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == LEN_W'(1));
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/updn_cmd_seq.sv
// rtl/updn_cmd_seq.sv - command sequencer driving a 3-bit up/down counter's ld/U_D/data_in pins
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous reset, ACTIVE-HIGH despite the name
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted (IDLE only)
//   cmd_op     in   0=HOLD 1=LOAD 2=UP 3=DOWN
//   cmd_val    in   LOAD value
//   cmd_len    in   run length for HOLD/UP/DOWN (0 = no-op); ignored for LOAD
//   count_in   in   counter's count output fed back
//   ld/U_D/data_in  out  counter control pins
//   busy       out  command executing
//   done       out  one-cycle pulse in the final active cycle of a command
//
// Build option: define UPDN_SAT_EN to saturate UP at all-ones and DOWN at zero
// (the cycle is driven as a hold); by default the counter wraps.
module updn_cmd_seq
    import updn_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_val,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] count_in,
    output logic             ld,
    output logic             U_D,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] val_q, val_d;

    logic             accept;
    logic [LEN_W-1:0] run_len;
    logic             rem_last;
    logic             rem_zero;

    assign accept  = cmd_valid && (state_q == IDLE);
    // LOAD always occupies exactly one cycle regardless of cmd_len.
    assign run_len = (op_t'(cmd_op) == LOAD) ? LEN_W'(1) : cmd_len;

    updn_len_cnt #(
        .LEN_W (LEN_W)
    ) u_rem (
        .clk      (clk),
        .rst      (reset_n),
        .load     (accept),
        .load_val (run_len),
        .dec      (state_q == RUN),
        .last     (rem_last),
        .zero     (rem_zero)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        val_d   = val_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = op_t'(cmd_op);
                    val_d = cmd_val;
                    // Zero-length HOLD/UP/DOWN is a silent no-op.
                    if (run_len != '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // zero can only be seen in RUN if state were corrupted; recover to IDLE.
                if (rem_last || rem_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q <= IDLE;
            op_q    <= HOLD;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            val_q   <= val_d;
        end
    end

    // The counter has no enable, so "hold" means reloading its own count.
    always_comb begin
        ld      = 1'b1;
        U_D     = 1'b0;
        data_in = count_in;
        if (state_q == RUN) begin
            case (op_q)
                LOAD: data_in = val_q;
`ifdef UPDN_SAT_EN
                UP: begin
                    if (count_in != '1) begin
                        ld  = 1'b0;
                        U_D = 1'b1;
                    end
                end
                DOWN: begin
                    if (count_in != '0) begin
                        ld = 1'b0;
                    end
                end
`else
                UP: begin
                    ld  = 1'b0;
                    U_D = 1'b1;
                end
                DOWN: ld = 1'b0;
`endif
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == RUN) && rem_last;

endmodule

// File: tb/tb_updn_cmd_seq.sv
// tb/tb_updn_cmd_seq.sv - self-checking bench for updn_cmd_seq with a behavioural counter and reference model
module tb_updn_cmd_seq;

    localparam int OP_HOLD = 0;
    localparam int OP_LOAD = 1;
    localparam int OP_UP   = 2;
    localparam int OP_DOWN = 3;
`ifdef UPDN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_val;
    logic [3:0] cmd_len;
    logic [2:0] count_in;
    logic       ld;
    logic       U_D;
    logic [2:0] data_in;
    logic       busy;
    logic       done;

    logic [2:0] cnt_m;

    int checks = 0;
    int errors = 0;
    int ref_cnt = 0;

    updn_cmd_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_val   (cmd_val),
        .cmd_len   (cmd_len),
        .count_in  (count_in),
        .ld        (ld),
        .U_D       (U_D),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Behavioural 3-bit up/down counter fed by the DUT, reset together with it.
    always @(posedge clk or posedge reset_n) begin
        if (reset_n)  cnt_m <= 3'd0;
        else if (ld)  cnt_m <= data_in;
        else if (U_D) cnt_m <= cnt_m + 3'd1;
        else          cnt_m <= cnt_m - 3'd1;
    end
    assign count_in = cnt_m;

    // Counter value after j active cycles of a command started from s.
    function automatic int ref_val(int op, int s, int val, int j);
        case (op)
            OP_LOAD: return (j >= 1) ? val : s;
            OP_UP:   return SAT ? ((s + j > 7) ? 7 : s + j) : (s + j) % 8;
            OP_DOWN: return SAT ? ((s - j < 0) ? 0 : s - j) : (((s - j) % 8) + 8) % 8;
            default: return s;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_val = 3'd0; cmd_len = 4'd0;
        @(posedge clk); @(negedge clk);
        checks++; if (ld !== 1'b1)      begin errors++; $display("FAIL reset_ld: got %0b want 1", ld); end
        checks++; if (U_D !== 1'b0)     begin errors++; $display("FAIL reset_ud: got %0b want 0", U_D); end
        checks++; if (data_in !== 3'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", data_in); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
            begin errors++; $display("FAIL reset_flags: got busy=%0b done=%0b ready=%0b want 0 0 1", busy, done, cmd_ready); end
        reset_n = 1'b0;
        ref_cnt = 0;
        @(posedge clk); @(negedge clk);
        checks++; if (cnt_m !== 3'd0 || ld !== 1'b1 || cmd_ready !== 1'b1)
            begin errors++; $display("FAIL post_reset_idle: got cnt=%0d ld=%0b ready=%0b want 0 1 1", cnt_m, ld, cmd_ready); end
    endtask

    // Issue one command from IDLE (called at a negedge) and check every active cycle.
    task automatic test_command(input int op, input int val, input int len, input string tag);
        int s, n, cur, eld, eud, edata;
        s = ref_cnt;
        n = (op == OP_LOAD) ? 1 : len;
        cmd_valid = 1'b1; cmd_op = 2'(op); cmd_val = 3'(val); cmd_len = 4'(len);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %0b want 1", tag, cmd_ready); end
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom_range(3)); cmd_val = 3'($urandom_range(7)); cmd_len = 4'($urandom_range(15));
        if (n == 0) begin
            checks++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || cnt_m !== 3'(s))
                begin errors++; $display("FAIL %s_noop: got busy=%0b done=%0b ready=%0b cnt=%0d want 0 0 1 %0d", tag, busy, done, cmd_ready, cnt_m, s); end
            @(posedge clk); @(negedge clk);
            checks++; if (cnt_m !== 3'(s) || done !== 1'b0)
                begin errors++; $display("FAIL %s_noop_hold: got cnt=%0d done=%0b want %0d 0", tag, cnt_m, done, s); end
            return;
        end
        for (int i = 1; i <= n; i++) begin
            cur = ref_val(op, s, val, i - 1);
            eud = 0;
            if (op == OP_LOAD)                         begin eld = 1; edata = val; end
            else if (op == OP_HOLD)                    begin eld = 1; edata = cur; end
            else if (op == OP_UP && SAT && cur == 7)   begin eld = 1; edata = cur; end
            else if (op == OP_DOWN && SAT && cur == 0) begin eld = 1; edata = cur; end
            else begin eld = 0; edata = 0; eud = (op == OP_UP) ? 1 : 0; end
            checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0)
                begin errors++; $display("FAIL %s_busy c%0d: got busy=%0b ready=%0b want 1 0", tag, i, busy, cmd_ready); end
            checks++; if (done !== 1'(i == n))
                begin errors++; $display("FAIL %s_done c%0d: got %0b want %0b", tag, i, done, (i == n)); end
            checks++; if (cnt_m !== 3'(cur))
                begin errors++; $display("FAIL %s_count c%0d: got %0d want %0d", tag, i, cnt_m, cur); end
            checks++; if (ld !== 1'(eld))
                begin errors++; $display("FAIL %s_ld c%0d: got %0b want %0b", tag, i, ld, eld); end
            else if (eld == 1 && data_in !== 3'(edata))
                begin errors++; $display("FAIL %s_data c%0d: got %0d want %0d", tag, i, data_in, edata); end
            else if (eld == 0 && U_D !== 1'(eud))
                begin errors++; $display("FAIL %s_ud c%0d: got %0b want %0b", tag, i, U_D, eud); end
            @(posedge clk); @(negedge clk);
        end
        ref_cnt = ref_val(op, s, val, n);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
            begin errors++; $display("FAIL %s_end_flags: got busy=%0b done=%0b ready=%0b want 0 0 1", tag, busy, done, cmd_ready); end
        checks++; if (cnt_m !== 3'(ref_cnt) || ld !== 1'b1 || data_in !== cnt_m)
            begin errors++; $display("FAIL %s_final: got cnt=%0d ld=%0b data=%0d want %0d 1 %0d", tag, cnt_m, ld, data_in, ref_cnt, ref_cnt); end
    endtask

    // HOLD 5 with a second command (UP 2) presented throughout the RUN.
    task automatic test_back_to_back();
        int exp2;
        test_command(OP_LOAD, 3, 0, "pre_hold_load");
        cmd_valid = 1'b1; cmd_op = 2'(OP_HOLD); cmd_val = 3'd6; cmd_len = 4'd5;
        @(posedge clk); @(negedge clk);
        cmd_op = 2'(OP_UP); cmd_val = 3'd0; cmd_len = 4'd2;
        for (int i = 1; i <= 5; i++) begin
            checks++; if (busy !== 1'b1 || done !== 1'(i == 5) || cnt_m !== 3'd3 || ld !== 1'b1)
                begin errors++; $display("FAIL b2b_hold c%0d: got busy=%0b done=%0b cnt=%0d ld=%0b want 1 %0b 3 1", i, busy, done, cnt_m, ld, (i == 5)); end
            @(posedge clk); @(negedge clk);
        end
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || cnt_m !== 3'd3)
            begin errors++; $display("FAIL b2b_gap: got ready=%0b busy=%0b cnt=%0d want 1 0 3", cmd_ready, busy, cnt_m); end
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || cnt_m !== 3'd3 || U_D !== 1'b1 || ld !== 1'b0)
            begin errors++; $display("FAIL b2b_up_c1: got busy=%0b done=%0b cnt=%0d ud=%0b ld=%0b want 1 0 3 1 0", busy, done, cnt_m, U_D, ld); end
        @(posedge clk); @(negedge clk);
        checks++; if (done !== 1'b1 || cnt_m !== 3'd4)
            begin errors++; $display("FAIL b2b_up_c2: got done=%0b cnt=%0d want 1 4", done, cnt_m); end
        @(posedge clk); @(negedge clk);
        exp2 = ref_val(OP_UP, 3, 0, 2);
        checks++; if (busy !== 1'b0 || cnt_m !== 3'(exp2))
            begin errors++; $display("FAIL b2b_up_end: got busy=%0b cnt=%0d want 0 %0d", busy, cnt_m, exp2); end
        ref_cnt = exp2;
    endtask

    task automatic test_mid_reset();
        cmd_valid = 1'b1; cmd_op = 2'(OP_UP); cmd_val = 3'd0; cmd_len = 4'd6;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got busy=%0b want 1", busy); end
        reset_n = 1'b1;
        #1;
        checks++; if (ld !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL midrst_out: got ld=%0b busy=%0b ready=%0b done=%0b want 1 0 1 0", ld, busy, cmd_ready, done); end
        checks++; if (data_in !== 3'd0 || U_D !== 1'b0)
            begin errors++; $display("FAIL midrst_data: got data=%0d ud=%0b want 0 0", data_in, U_D); end
        @(posedge clk); @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL midrst_hold: got done=%0b busy=%0b want 0 0", done, busy); end
        reset_n = 1'b0;
        ref_cnt = 0;
        @(posedge clk); @(negedge clk);
        test_command(OP_LOAD, 4, 9, "post_rst_load");
    endtask

    task automatic test_random();
        int op, val, len;
        for (int k = 0; k < 24; k++) begin
            op  = int'($urandom_range(3));
            val = int'($urandom_range(7));
            len = int'($urandom_range(15));
            test_command(op, val, len, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_command(OP_LOAD, 5, 0, "load5");
        test_command(OP_UP, 0, 4, "up4");
        test_command(OP_LOAD, 2, 3, "load2");
        test_command(OP_DOWN, 0, 3, "down3");
        test_back_to_back();
        test_command(OP_UP, 0, 0, "up0");
        test_command(OP_DOWN, 0, 15, "down15");
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/updn_cmd_seq.md
Name: updn_cmd_seq

Overview:
Command sequencer directly upstream of the 3-bit up/down counter. Accepts LOAD/UP/DOWN/HOLD commands over a valid/ready handshake and drives the counter's `ld`, `U_D` and `data_in` pins for a programmed number of cycles. The counter has no enable pin, so this block emulates hold by reloading the fed-back count. Completion is reported with a one-cycle `done` pulse.

Parameters:
- WIDTH, 3, counter data width; matches counter `data_in`/`count`.
- LEN_W, 4, width of `cmd_len`; max run is 2^LEN_W-1 cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-high reset (asserted = 1, despite the name).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command (high only in IDLE).
- cmd_op  input  2  0=HOLD, 1=LOAD, 2=UP, 3=DOWN.
- cmd_val  input  WIDTH  load value (LOAD only).
- cmd_len  input  LEN_W  cycle count for HOLD/UP/DOWN; ignored for LOAD.
- count_in  input  WIDTH  feedback from the counter's `count` output.
- ld  output  1  to counter `ld`.
- U_D  output  1  to counter `U_D`; 1 = up.
- data_in  output  WIDTH  to counter `data_in`.
- busy  output  1  command executing.
- done  output  1  one-cycle pulse in the final active cycle of a command.

Behaviour:
- States: IDLE and RUN. Registered: `state`, `op_q`, `val_q`, `rem_q` (LEN_W bits).
- **IDLE**
  - `cmd_ready`=1, `busy`=0, `done`=0.
  - Outputs: `ld`=1, `data_in`=`count_in`, `U_D`=0, so the counter holds.
- **Accept**
  - A command is taken on the rising edge where `cmd_valid` & `cmd_ready`.
  - `op_q`, `val_q` latched; `rem_q` = (`cmd_op`==LOAD) ? 1 : `cmd_len`.
  - If `rem_q` would be 0 (HOLD/UP/DOWN with `cmd_len`=0): stay in IDLE, assert no `done`, treat as a no-op.
  - Otherwise go to RUN.
- **RUN** (`cmd_ready`=0, `busy`=1). Outputs each cycle, combinational from registered state and `count_in`:
  - LOAD: `ld`=1, `data_in`=`val_q`.
  - UP: `ld`=0, `U_D`=1.
  - DOWN: `ld`=0, `U_D`=0.
  - HOLD: `ld`=1, `data_in`=`count_in`.
  - When `ld`=0, `data_in` = `count_in` (don't-care to the counter; fixed for determinism).
  - `rem_q` decrements each RUN cycle.
  - `done`=1 when `rem_q`==1; the next edge returns to IDLE.
- **Latency**
  - A command accepted at edge k drives outputs from cycle k+1 for N cycles, with `done` in cycle k+N.
  - The counter reflects the final result after edge k+N+1.
  - `cmd_ready` is high again in cycle k+N+1, so back-to-back commands have a 1-cycle IDLE gap, which holds the counter.
- **Wrap** (default): UP from 2^WIDTH-1 wraps to 0; DOWN from 0 wraps to 2^WIDTH-1. The counter's modular arithmetic is passed through unchanged.
- **Handshake**
  - `cmd_valid` while busy is ignored; the payload must stay stable until accepted.
  - `cmd_valid` may drop without penalty.
- **Reset** (asynchronous, any time, including mid-RUN)
  - `state`=IDLE, `op_q`=HOLD, `val_q`=0, `rem_q`=0.
  - Resulting outputs: `ld`=1, `U_D`=0, `data_in`=`count_in` (0 while the counter is also reset), `busy`=0, `done`=0, `cmd_ready`=1.
  - The in-flight command is dropped with no `done`.

Optional Feature:
- Macro: UPDN_SAT_EN.
- Defined:
  - During UP, if `count_in`==2^WIDTH-1, the cycle is driven as HOLD (`ld`=1, `data_in`=`count_in`).
  - During DOWN, if `count_in`==0, likewise.
  - `rem_q` still decrements, so command duration is unchanged.
- Undefined: wrap as above; no comparators are synthesised.

Decomposition:
- Package updn_pkg:
  - `op_t` enum (HOLD, LOAD, UP, DOWN).
  - `state_t` enum (IDLE, RUN).
  - Default-width localparams.
- Sub-module updn_len_cnt: loadable LEN_W-bit down-counter with `load`/`dec` inputs and `last` (==1) and `zero` flags. It is instantiated once for `rem_q`.
- Top level holds the FSM and the output mux.

Test Plan:
- After reset, LOAD `cmd_val`=5: `ld`=1, `data_in`=5 for 1 cycle, with `done` in that cycle. Counter = 5, then held at 5 while IDLE.
- Counter=5, UP `cmd_len`=4: counter sequence 6,7,0,1; `done` in the 4th cycle; then holds at 1. With UPDN_SAT_EN: 6,7,7,7.
- Counter=2, DOWN `cmd_len`=3: counter 1,0,7. With UPDN_SAT_EN: 1,0,0.
- Counter=3, HOLD `cmd_len`=5: counter stays 3 for 5 cycles, `busy`=1, `done` in the 5th cycle. A second command with `cmd_valid` held during RUN is accepted only at the first cycle with `cmd_ready`=1.
- UP `cmd_len`=0: not executed, no `done`, `busy` stays 0, counter unchanged.
- Reset asserted in the 2nd cycle of UP `cmd_len`=6: outputs immediately `ld`=1, `busy`=0, `cmd_ready`=1, no `done`. After release, a LOAD of 4 executes normally.
